// File: rtl/reg_scoreboard.sv
// Issue-side hazard scoreboard in front of the 16x16 register file; owns its write port.
// Latency: write pass-through 0 cycles, state 1 cycle. Backpressure: iss_stall holds decode on RAW/WAW.
module reg_scoreboard #(
   parameter int NREG    = 16,
   parameter int AW      = 4,
   parameter int DW      = 16,
   parameter int TIMEOUT = 63
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_src1,
   input  logic [AW-1:0]   iss_src2,
   input  logic            iss_use1,
   input  logic            iss_use2,
   input  logic            iss_wr,
   input  logic [AW-1:0]   iss_dst,
   output logic            iss_stall,
   input  logic            ret_valid,
   input  logic [AW-1:0]   ret_dst,
   input  logic [DW-1:0]   ret_data,
   output logic            rf_WriteReg,
   output logic [AW-1:0]   rf_DstReg,
   output logic [DW-1:0]   rf_DstData,
   output logic [NREG-1:0] busy_vec,
   output logic [AW:0]     outstanding,
   output logic            idle,
   output logic            err_spurious,
   output logic            err_timeout
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   logic [NREG-1:0] r_busy;
   logic [AW:0]     r_cnt;
   logic            r_idle;
   logic            r_err_spur;
   logic            r_err_to;
   logic [CW-1:0]   r_age [NREG];

   logic [NREG-1:0] w_clr;
   logic [NREG-1:0] w_free;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_busy_nxt;
   logic [AW:0]     w_cnt_nxt;
   logic            w_acc;
   logic            w_any_to;
   logic [CW-1:0]   w_age_nxt [NREG];

   assign rf_WriteReg = ret_valid;
   assign rf_DstReg   = ret_dst;
   assign rf_DstData  = ret_data;

   // A register retiring this cycle reads as free: the register file bypasses the write.
   always_comb begin
      w_clr = '0;
      if (ret_valid) w_clr[ret_dst] = 1'b1;
   end

   assign w_free    = ~r_busy | w_clr;
   assign iss_stall = iss_valid && ((iss_use1 && !w_free[iss_src1]) ||
                                    (iss_use2 && !w_free[iss_src2]) ||
                                    (iss_wr   && !w_free[iss_dst]));
   assign w_acc     = iss_valid && !iss_stall;

   always_comb begin
      w_set = '0;
      if (w_acc && iss_wr) w_set[iss_dst] = 1'b1;
   end

   assign w_busy_nxt = (r_busy & ~w_clr) | w_set;

   always_comb begin
      w_cnt_nxt = '0;
      for (int i = 0; i < NREG; i++) begin
         w_cnt_nxt = w_cnt_nxt + {{AW{1'b0}}, w_busy_nxt[i]};
      end
   end

   // A fresh issue restarts the age even when it overlaps the old write's retire.
   always_comb begin
      w_any_to = 1'b0;
      for (int i = 0; i < NREG; i++) begin
         w_age_nxt[i] = '0;
         if (r_busy[i] && w_busy_nxt[i] && !w_set[i]) begin
            w_age_nxt[i] = (r_age[i] == TMAX) ? TMAX : r_age[i] + 1'b1;
         end
         if (r_age[i] == TMAX) w_any_to = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy     <= '0;
         r_cnt      <= '0;
         r_idle     <= 1'b1;
         r_err_spur <= 1'b0;
         r_err_to   <= 1'b0;
         for (int i = 0; i < NREG; i++) r_age[i] <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
         r_idle <= (w_cnt_nxt == '0);
         if (ret_valid && !r_busy[ret_dst]) r_err_spur <= 1'b1;
         if (w_any_to) r_err_to <= 1'b1;
         for (int i = 0; i < NREG; i++) r_age[i] <= w_age_nxt[i];
      end
   end

   assign busy_vec     = r_busy;
   assign outstanding  = r_cnt;
   assign idle         = r_idle;
   assign err_spurious = r_err_spur;
   assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed hazard scenarios then random traffic against a reference model.
// Expected post-edge state is queued per cycle and popped after the edge.
module tb_reg_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid, iss_use1, iss_use2, iss_wr;
   logic [3:0]  iss_src1, iss_src2, iss_dst;
   logic        iss_stall;
   logic        ret_valid;
   logic [3:0]  ret_dst;
   logic [15:0] ret_data;
   logic        rf_WriteReg;
   logic [3:0]  rf_DstReg;
   logic [15:0] rf_DstData;
   logic [15:0] busy_vec;
   logic [4:0]  outstanding;
   logic        idle, err_spurious, err_timeout;

   always #5 clk = ~clk;

   reg_scoreboard dut (
      .clk(clk), .rst(rst),
      .iss_valid(iss_valid), .iss_src1(iss_src1), .iss_src2(iss_src2),
      .iss_use1(iss_use1), .iss_use2(iss_use2), .iss_wr(iss_wr), .iss_dst(iss_dst),
      .iss_stall(iss_stall),
      .ret_valid(ret_valid), .ret_dst(ret_dst), .ret_data(ret_data),
      .rf_WriteReg(rf_WriteReg), .rf_DstReg(rf_DstReg), .rf_DstData(rf_DstData),
      .busy_vec(busy_vec), .outstanding(outstanding), .idle(idle),
      .err_spurious(err_spurious), .err_timeout(err_timeout)
   );

   typedef struct packed {
      logic [15:0] busy;
      logic [4:0]  outst;
      logic        idl;
      logic        spur;
      logic        to;
      logic        chk_to;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] m_busy = '0;
   logic        m_spur = 1'b0;
   logic        m_to   = 1'b0;
   int          m_age[16];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_in();
      iss_valid = 0; iss_use1 = 0; iss_use2 = 0; iss_wr = 0;
      iss_src1 = 0; iss_src2 = 0; iss_dst = 0;
      ret_valid = 0; ret_dst = 0; ret_data = 0;
   endtask

   task automatic issue(input logic [3:0] s1, input logic u1, input logic wr, input logic [3:0] d);
      iss_valid = 1; iss_src1 = s1; iss_use1 = u1; iss_src2 = 0; iss_use2 = 0;
      iss_wr = wr; iss_dst = d;
   endtask

   task automatic retire(input logic [3:0] d, input logic [15:0] v);
      ret_valid = 1; ret_dst = d; ret_data = v;
   endtask

   // One clock: check combinational outputs, advance the model, queue and compare post-edge state.
   task automatic step(input int exp_stall);
      logic [15:0] clr, set, nb;
      logic        st, any_to;
      int          maxage;
      exp_t        e, g;
      #2;
      clr = '0;
      if (ret_valid) clr[ret_dst] = 1'b1;
      st = iss_valid && ((iss_use1 && m_busy[iss_src1] && !clr[iss_src1]) ||
                         (iss_use2 && m_busy[iss_src2] && !clr[iss_src2]) ||
                         (iss_wr   && m_busy[iss_dst]  && !clr[iss_dst]));
      check("stall_model", {31'd0, iss_stall}, {31'd0, st});
      if (exp_stall >= 0) check("stall_dir", {31'd0, iss_stall}, exp_stall);
      check("rf_wr", {31'd0, rf_WriteReg}, {31'd0, ret_valid});
      if (ret_valid) begin
         check("rf_dst", {28'd0, rf_DstReg}, {28'd0, ret_dst});
         check("rf_dat", {16'd0, rf_DstData}, {16'd0, ret_data});
      end
      set = '0;
      if (iss_valid && !st && iss_wr) set[iss_dst] = 1'b1;
      nb = (m_busy & ~clr) | set;
      if (!rst) begin
         m_busy = '0; m_spur = 0; m_to = 0;
         for (int i = 0; i < 16; i++) m_age[i] = 0;
      end else begin
         any_to = 0;
         for (int i = 0; i < 16; i++) if (m_age[i] == 63) any_to = 1;
         if (ret_valid && !m_busy[ret_dst]) m_spur = 1;
         if (any_to) m_to = 1;
         for (int i = 0; i < 16; i++) begin
            if (m_busy[i] && nb[i] && !set[i]) m_age[i] = (m_age[i] < 63) ? m_age[i] + 1 : 63;
            else m_age[i] = 0;
         end
         m_busy = nb;
      end
      maxage = 0;
      for (int i = 0; i < 16; i++) if (m_age[i] > maxage) maxage = m_age[i];
      e.busy = m_busy; e.outst = 5'($countones(m_busy)); e.idl = (m_busy == 0);
      e.spur = m_spur; e.to = m_to; e.chk_to = (maxage < 55);
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      g = exp_q.pop_front();
      check("busy_vec", {16'd0, busy_vec}, {16'd0, g.busy});
      check("outstanding", {27'd0, outstanding}, {27'd0, g.outst});
      check("idle", {31'd0, idle}, {31'd0, g.idl});
      check("err_spurious", {31'd0, err_spurious}, {31'd0, g.spur});
      if (g.chk_to) check("err_timeout", {31'd0, err_timeout}, {31'd0, g.to});
   endtask

   initial begin
      int pick;
      for (int i = 0; i < 16; i++) m_age[i] = 0;
      idle_in();
      rst = 0;
      for (int i = 0; i < 4; i++) step(0);
      check("rst_busy", {16'd0, busy_vec}, 32'd0);
      check("rst_outst", {27'd0, outstanding}, 32'd0);
      check("rst_idle", {31'd0, idle}, 32'd1);
      check("rst_errs", {30'd0, err_spurious, err_timeout}, 32'd0);
      rst = 1;

      // RAW: reader of r2 waits until r2 retires, released in the retire cycle
      issue(0, 0, 1, 2); step(0);
      issue(2, 1, 0, 0); step(1);
      step(1);
      step(1);
      retire(2, 16'h2222); step(0);
      idle_in();

      // same-cycle issue and retire on r4: set wins
      issue(0, 0, 1, 4); step(0);
      retire(4, 16'h4444); step(0);
      check("r4_stays_busy", {31'd0, busy_vec[4]}, 32'd1);
      idle_in(); retire(4, 16'h0004); step(0);
      check("r4_cleared", {16'd0, busy_vec}, 32'd0);
      idle_in();

      // WAW on r6; independent write to r8 proceeds
      issue(0, 0, 1, 6); step(0);
      issue(0, 0, 1, 6); step(1);
      issue(0, 0, 1, 8); step(0);
      check("outst_two", {27'd0, outstanding}, 32'd2);
      idle_in(); retire(6, 16'h0006); step(0);
      retire(8, 16'h0008); step(0);
      check("idle_again", {31'd0, idle}, 32'd1);
      idle_in();

      // spurious retire on r7
      retire(7, 16'h7777); step(0);
      check("spur_set", {31'd0, err_spurious}, 32'd1);
      idle_in();
      for (int i = 0; i < 3; i++) step(0);
      check("spur_sticky", {31'd0, err_spurious}, 32'd1);

      // r3 never retires: timeout, then reset clears everything
      issue(0, 0, 1, 3); step(0);
      idle_in();
      for (int i = 0; i < 30; i++) step(0);
      check("to_early", {31'd0, err_timeout}, 32'd0);
      for (int i = 0; i < 40; i++) step(0);
      check("to_set", {31'd0, err_timeout}, 32'd1);
      issue(0, 0, 1, 5); retire(3, 16'h3333);
      rst = 0; step(-1);
      rst = 1; idle_in();
      check("rst_mid_busy", {16'd0, busy_vec}, 32'd0);
      check("rst_mid_errs", {30'd0, err_spurious, err_timeout}, 32'd0);
      check("rst_mid_idle", {31'd0, idle}, 32'd1);

      // random traffic; retires mostly target busy registers
      for (int n = 0; n < 300; n++) begin
         iss_valid = 1'($urandom);
         iss_src1 = 4'($urandom); iss_src2 = 4'($urandom); iss_dst = 4'($urandom);
         iss_use1 = 1'($urandom); iss_use2 = 1'($urandom); iss_wr = 1'($urandom);
         ret_valid = 0; ret_dst = 0; ret_data = 16'($urandom);
         if ($urandom_range(0, 15) == 0) begin
            ret_valid = 1; ret_dst = 4'($urandom);
         end else if (m_busy != 0 && $urandom_range(0, 2) != 0) begin
            pick = $urandom_range(0, 15);
            while (!m_busy[pick[3:0]]) pick = (pick + 1) % 16;
            ret_valid = 1; ret_dst = pick[3:0];
         end
         step(-1);
      end
      idle_in();
      step(-1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
